// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: sequencer state encodings and the default
// operand width. Reused by the hazard unit and the execute stage.
package muldiv_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mul_state_e;

  // True while the sequencer owns the adder and HI/LO are not yet final.
  function automatic logic mul_state_busy(input mul_state_e st);
    return (st == S_RUN) || (st == S_FIX);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditionally adds the multiplicand into the
// accumulator and shifts the multiplicand/multiplier pair. Holds the single
// 2*WIDTH-bit adder of the multiplier.
module mul_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  // Add when the current multiplier LSB is set; the carry out of 2*WIDTH is dropped.
  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mcand_next  = mcand << 1;
    mplier_next = mplier >> 1;
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MULT/MULTU sequencer for the execute stage. Runs WIDTH
// shift-and-add iterations on unsigned magnitudes, then applies the sign in a
// single FIX cycle and writes HI/LO.
// Optional feature: define MUL_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits are all zero.
module mul_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [2*WIDTH-1:0] One2w    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LastIter = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] acc_step, mcand_step;
  logic [WIDTH-1:0]   mplier_step;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] product;
  logic               last_iter;

  mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_next   (acc_step),
    .mcand_next (mcand_step),
    .mplier_next(mplier_step)
  );

  // Operand magnitudes; the most negative value maps to itself, which is its
  // correct unsigned magnitude.
  always_comb begin
    mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // Signed result applied once at the end, over the full 2*WIDTH bits.
  always_comb begin
    product = neg_q ? ((~acc_q) + One2w) : acc_q;
  end

  // Iteration exit condition.
  always_comb begin
`ifdef MUL_EARLY_TERM_EN
    last_iter = (count_q == LastIter) || (mplier_step == '0);
`else
    last_iter = (count_q == LastIter);
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          count_d  = '0;
          neg_d    = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        count_d  = count_q + CNT_W'(1);
        if (last_iter) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        {hi_d, lo_d} = product;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the operation and drops any same-cycle start; HI/LO keep
    // the last completed product.
    if (flush) begin
      state_d  = S_IDLE;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Moore outputs plus the early stall for a start arriving in IDLE.
  always_comb begin
    hi    = hi_q;
    lo    = lo_q;
    busy  = mul_state_busy(state_q);
    done  = (state_q == S_DONE);
    stall = busy | (start & (state_q == S_IDLE));
  end

endmodule
